// File: rtl/act_mux_sequencer_pkg.sv
// Shared definitions for the s2 mux feeder: FSM state encoding and bank geometry.
package act_mux_sequencer_pkg;

  localparam int unsigned ACT_WORDS = 4;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SEQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/act_sel_enc.sv
// Maps a word index onto the s2 select pins so that {A1|B1, A0&B0} equals the index.
module act_sel_enc (
  input  logic [1:0] sel_idx,
  output logic       a1,
  output logic       b1,
  output logic       a0,
  output logic       b0
);

  assign a1 = sel_idx[1];
  assign b1 = 1'b0;
  assign a0 = sel_idx[0];
  assign b0 = sel_idx[0];

endmodule

// File: rtl/act_mux_sequencer.sv
// Loads four words into a bank, then walks the s2 selects over them one per clock.
module act_mux_sequencer
  import act_mux_sequencer_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D0,
  output logic [N-1:0] D1,
  output logic [N-1:0] D2,
  output logic [N-1:0] D3,
  output logic         A1,
  output logic         B1,
  output logic         A0,
  output logic         B0,
  output logic [1:0]   sel_idx
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [N-1:0]       bank_q [ACT_WORDS];
  logic [N-1:0]       bank_d [ACT_WORDS];
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, bank write and registered status decode
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    sel_idx_d = sel_idx_q;
    bank_d    = bank_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          bank_d[wr_cnt_q] = in_data;
          wr_cnt_d         = wr_cnt_q + IDX_W'(1);
          if (wr_cnt_q == IDX_W'(ACT_WORDS - 1)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (start) begin
          state_d   = ST_SEQ;
          sel_idx_d = '0;
        end
      end
      ST_SEQ: begin
        // Wraps to 0 on the last word so selects fall back to D0 in DONE
        sel_idx_d = sel_idx_q + IDX_W'(1);
        if (sel_idx_q == IDX_W'(ACT_WORDS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_FILL;
        sel_idx_d = '0;
      end
      default: begin
        state_d   = ST_FILL;
        sel_idx_d = '0;
      end
    endcase
    in_ready_d = (state_d == ST_FILL);
    busy_d     = (state_d == ST_SEQ);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      sel_idx_q  <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(ACT_WORDS); i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      sel_idx_q  <= sel_idx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < int'(ACT_WORDS); i++) bank_q[i] <= bank_d[i];
    end
  end

  act_sel_enc u_sel_enc (
    .sel_idx (sel_idx_q),
    .a1      (A1),
    .b1      (B1),
    .a0      (A0),
    .b0      (B0)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_idx  = sel_idx_q;
  assign D0       = bank_q[0];
  assign D1       = bank_q[1];
  assign D2       = bank_q[2];
  assign D3       = bank_q[3];

endmodule

// File: tb/tb_act_mux_sequencer.sv
// Directed bench: sequencer feeding a behavioural registered 4:1 s2 mux, N=8.
module tb_act_mux_sequencer;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         start;
  logic         busy;
  logic         done;
  logic [N-1:0] d0, d1, d2, d3;
  logic         a1, b1, a0, b0;
  logic [1:0]   sel_idx;
  logic [N-1:0] s2_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  act_mux_sequencer #(.N(N)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .D0       (d0),
    .D1       (d1),
    .D2       (d2),
    .D3       (d3),
    .A1       (a1),
    .B1       (b1),
    .A0       (a0),
    .B0       (b0),
    .sel_idx  (sel_idx)
  );

  // Registered 4:1 s2 stage: S1 = A1|B1, S0 = A0&B0
  always_ff @(posedge clk) begin
    if (clr) s2_out <= '0;
    else begin
      case ({a1 | b1, a0 & b0})
        2'd0:    s2_out <= d0;
        2'd1:    s2_out <= d1;
        2'd2:    s2_out <= d2;
        default: s2_out <= d3;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bank(input string tag, input logic [N-1:0] w0, input logic [N-1:0] w1,
                          input logic [N-1:0] w2, input logic [N-1:0] w3);
    chk({tag, "_d0"}, 32'(d0), 32'(w0));
    chk({tag, "_d1"}, 32'(d1), 32'(w1));
    chk({tag, "_d2"}, 32'(d2), 32'(w2));
    chk({tag, "_d3"}, 32'(d3), 32'(w3));
  endtask

  task automatic load4(input logic [N-1:0] w0, input logic [N-1:0] w1,
                       input logic [N-1:0] w2, input logic [N-1:0] w3);
    logic [N-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Pulse start in READY and check s2 output/done for cycles t+1..t+6
  task automatic run_pass(input string tag, input logic [N-1:0] w0, input logic [N-1:0] w1,
                          input logic [N-1:0] w2, input logic [N-1:0] w3);
    logic [N-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
    chk({tag, "_sel_t1"}, 32'(sel_idx), 32'd0);
    chk({tag, "_done_t1"}, 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("%s_s2_w%0d", tag, k), 32'(s2_out), 32'(w[k]));
      chk($sformatf("%s_done_t%0d", tag, k + 2), 32'(done), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) chk($sformatf("%s_sel_t%0d", tag, k + 2), 32'(sel_idx), 32'(k + 1));
    end
    chk({tag, "_busy_t5"}, 32'(busy), 32'd0);
    chk({tag, "_sel_t5"}, 32'(sel_idx), 32'd0);
    step();
    chk({tag, "_done_t6"}, 32'(done), 32'd0);
    chk({tag, "_rdy_t6"}, 32'(in_ready), 32'd1);
    chk({tag, "_selpins_t6"}, 32'({a1, b1, a0, b0}), 32'd0);
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0;

    // 1. reset
    step();
    chk("rst_s2", 32'(s2_out), 32'd0);
    step();
    clr = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel", 32'(sel_idx), 32'd0);
    chk("rst_pins", 32'({a1, b1, a0, b0}), 32'd0);
    chk_bank("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // 2. back-to-back load then pass
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    chk("b2b_rdy", 32'(in_ready), 32'd0);
    chk_bank("b2b", 8'h11, 8'h22, 8'h33, 8'h44);
    run_pass("b2b", 8'h11, 8'h22, 8'h33, 8'h44);

    // 3. gapped valid, then drops in READY
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? N'(8'h10 * (i / 2 + 5)) : 8'hEE;
      step();
    end
    in_valid = 1'b0;
    chk("gap_rdy", 32'(in_ready), 32'd0);
    chk_bank("gap", 8'h50, 8'h60, 8'h70, 8'h80);
    in_valid = 1'b1; in_data = 8'hFF;
    step(); step(); step();
    in_valid = 1'b0;
    chk("drop_rdy", 32'(in_ready), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk_bank("drop", 8'h50, 8'h60, 8'h70, 8'h80);
    run_pass("gap", 8'h50, 8'h60, 8'h70, 8'h80);

    // 4. start held through fill, 4th accept and SEQ
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = N'(8'hA0 + i);
      step();
      chk($sformatf("hold_busy_fill%0d", i), 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    chk("hold_rdy_after4", 32'(in_ready), 32'd0);
    step();
    chk("hold_busy_t1", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("hold_s2_w%0d", k), 32'(s2_out), 32'(8'hA0 + k));
    end
    chk("hold_done", 32'(done), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_norestart%0d", i), 32'(busy), 32'd0);
      chk($sformatf("hold_fill%0d", i), 32'(in_ready), 32'd1);
      chk($sformatf("hold_nodone%0d", i), 32'(done), 32'd0);
      step();
    end
    start = 1'b0;

    // 5. clr in cycle t+3 of SEQ
    load4(8'h12, 8'h34, 8'h56, 8'h78);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s2", 32'(s2_out), 32'd0);
    chk("abort_sel", 32'(sel_idx), 32'd0);
    chk_bank("abort", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk("abort_done2", 32'(done), 32'd0);

    // 6. two consecutive passes with new words
    load4(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    run_pass("p1", 8'hA5, 8'h5A, 8'hC3, 8'h3C);
    chk_bank("p1_retain", 8'hA5, 8'h5A, 8'hC3, 8'h3C);
    load4(8'h00, 8'hFF, 8'h0F, 8'hF0);
    chk_bank("p2", 8'h00, 8'hFF, 8'h0F, 8'hF0);
    run_pass("p2", 8'h00, 8'hFF, 8'h0F, 8'hF0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
